// File: rtl/aes_mode_ctrl.sv
// Block-cipher mode controller: queues plaintext blocks, feeds an external AES core
// and applies ECB/CBC/CTR chaining around it.
module aes_mode_ctrl #(
  parameter int BLOCK_W  = 128,
  parameter int CTR_W    = 32,
  parameter int IN_DEPTH = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         cfg_mode,
  input  logic [BLOCK_W-1:0] cfg_iv,
  input  logic               cfg_load,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               core_ready,
  output logic [BLOCK_W-1:0] core_data_in,
  input  logic               core_valid,
  input  logic [BLOCK_W-1:0] core_data_out,
  output logic               busy,
  output logic               err,
  output logic [1:0]         state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // producer holds valid and data stable until then, and ready never waits on valid.

  localparam int AW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [AW:0] FIFO_FULL_CNT = (AW + 1)'(IN_DEPTH);
  localparam logic [BLOCK_W-1:0] CTR_MASK = {BLOCK_W{1'b1}} >> (BLOCK_W - CTR_W);

  localparam logic [1:0] MODE_ECB = 2'b00;
  localparam logic [1:0] MODE_CBC = 2'b01;
  localparam logic [1:0] MODE_CTR = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t state, state_n;

  logic [BLOCK_W-1:0] fifo_mem [IN_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        fifo_cnt;
  logic               fifo_empty, fifo_full;
  logic               rdy_en;
  logic               push, pop;

  logic [BLOCK_W-1:0] pt_reg, out_reg, chain, chain_inc, operand;
  logic [1:0]         mode;
  logic [CW-1:0]      to_cnt;
  logic               err_reg;
  logic               capture, timeout_hit, load_ok;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
  // Full is judged before any same-cycle pop: there is no bypass path.
  assign in_ready   = rdy_en && !fifo_full;
  assign push       = in_valid && in_ready;
  assign pop        = (state == IDLE) && !fifo_empty;

  assign out_valid  = (state == OUT);
  assign out_data   = out_reg;
  assign core_ready = (state == ISSUE);
  assign busy       = (state != IDLE) || !fifo_empty;
  assign err        = err_reg;
  assign state_dbg  = state;
  assign load_ok    = cfg_load && !busy && !out_valid;

  assign chain_inc  = (chain & ~CTR_MASK) | ((chain + BLOCK_W'(1)) & CTR_MASK);

  always_comb begin
    operand = pt_reg;
    case (mode)
      MODE_CBC: operand = pt_reg ^ chain;
      MODE_CTR: operand = chain;
      default:  operand = pt_reg;
    endcase
  end

  assign core_data_in = (state == ISSUE) ? operand : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE:  if (!fifo_empty) state_n = ISSUE;
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (core_valid) begin
          capture = 1'b1;
          state_n = OUT;
        end else if (to_cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          state_n     = IDLE;
        end
      end
      OUT:   if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt_reg  <= '0;
      out_reg <= '0;
      chain   <= '0;
      mode    <= MODE_ECB;
      to_cnt  <= '0;
      err_reg <= 1'b0;
    end else begin
      err_reg <= timeout_hit || (cfg_load && (!load_ok || cfg_mode == MODE_RSV));
      if (pop) pt_reg <= fifo_mem[rd_ptr];

      if (state == WAIT && state_n == WAIT) begin
        to_cnt <= to_cnt + CW'(1);
      end else begin
        to_cnt <= '0;
      end

      if (capture) begin
        out_reg <= (mode == MODE_CTR) ? (pt_reg ^ core_data_out) : core_data_out;
        if (mode == MODE_CBC) chain <= core_data_out;
        else if (mode == MODE_CTR) chain <= chain_inc;
      end else if (load_ok) begin
        // A reserved mode still loads the chain but runs as ECB.
        chain <= cfg_iv;
        mode  <= (cfg_mode == MODE_RSV) ? MODE_ECB : cfg_mode;
      end
    end
  end

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Directed bench for aes_mode_ctrl with a behavioural core that returns data_in+1
// three cycles after each start pulse.
module tb_aes_mode_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [1:0]   cfg_mode = 2'b00;
  logic [127:0] cfg_iv = '0;
  logic         cfg_load = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         core_ready;
  logic [127:0] core_data_in;
  logic         core_valid;
  logic [127:0] core_data_out;
  logic         busy;
  logic         err;
  logic [1:0]   state_dbg;

  int tests = 0;
  int fails = 0;

  logic [127:0] exp_q[$];

  aes_mode_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_iv(cfg_iv), .cfg_load(cfg_load),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_ready(core_ready), .core_data_in(core_data_in),
    .core_valid(core_valid), .core_data_out(core_data_out),
    .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Core model plus a manual override for stray strobes.
  logic         core_en = 1'b1;
  logic         cv_model = 1'b0;
  logic         cv_manual = 1'b0;
  logic [127:0] model_data = '0;
  logic [127:0] manual_data = '0;
  logic [127:0] core_buf = '0;
  int           core_cnt = 0;

  assign core_valid    = cv_model | cv_manual;
  assign core_data_out = cv_manual ? manual_data : model_data;

  always @(negedge clk) begin
    cv_model = 1'b0;
    if (!rst_n) begin
      core_cnt = 0;
    end else begin
      if (core_cnt > 0) begin
        core_cnt = core_cnt - 1;
        if (core_cnt == 0) begin
          cv_model   = 1'b1;
          model_data = core_buf;
        end
      end
      if (core_ready && core_en) begin
        core_cnt = 3;
        core_buf = core_data_in + 128'd1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [1:0] m, input logic [127:0] iv, input logic exp_err);
    cfg_mode = m;
    cfg_iv   = iv;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    check_bit("load_err", err, exp_err);
    tick();
    check_bit("load_err_width", err, 1'b0);
  endtask

  task automatic push(input logic [127:0] d);
    check_bit("push_in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_core_ready(output int n);
    n = 0;
    while (!core_ready && n < 200) begin
      tick();
      n++;
    end
    check_bit("core_ready_seen", core_ready, 1'b1);
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    check_bit("out_valid_seen", out_valid, 1'b1);
  endtask

  task automatic take_output;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_bit("out_valid_drop", out_valid, 1'b0);
    check_bit("idle_busy", busy, 1'b0);
  endtask

  typedef struct {
    logic         do_load;
    logic [1:0]   mode;
    logic [127:0] iv;
    logic         exp_err;
    logic [127:0] pt;
    logic [127:0] exp_core;
    logic [127:0] exp_out;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n;
    logic seen_bad;

    vecs[0] = '{1'b1, 2'b00, 128'h0, 1'b0, 128'h0, 128'h0, 128'h1};
    vecs[1] = '{1'b0, 2'b00, 128'h0, 1'b0, 128'h1234, 128'h1234, 128'h1235};
    vecs[2] = '{1'b1, 2'b01, 128'hFF, 1'b0, 128'h0F, 128'hF0, 128'hF1};
    vecs[3] = '{1'b0, 2'b01, 128'h0, 1'b0, 128'h00, 128'hF1, 128'hF2};
    vecs[4] = '{1'b1, 2'b10, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_FFFFFFFF, 1'b0, 128'h5,
                128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_FFFFFFFF,
                128'hAAAAAAAA_AAAAAAAA_AAAAAAAB_00000005};
    vecs[5] = '{1'b0, 2'b10, 128'h0, 1'b0, 128'h0,
                128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_00000000,
                128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_00000001};
    vecs[6] = '{1'b1, 2'b11, 128'h77, 1'b1, 128'h9, 128'h9, 128'hA};
    vecs[7] = '{1'b1, 2'b01, 128'h0, 1'b0, 128'h3, 128'h3, 128'h4};
    vecs[8] = '{1'b1, 2'b10, 128'h100, 1'b0, 128'hF0, 128'h100, 128'h1F1};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check_bit("rst_in_ready", in_ready, 1'b0);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 128'h0);
    check_bit("rst_core_ready", core_ready, 1'b0);
    check("rst_core_data_in", core_data_in, 128'h0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_err", err, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    check_bit("rel_in_ready_low", in_ready, 1'b0);
    tick();
    check_bit("rel_in_ready_high", in_ready, 1'b1);
    check("rel_state", 128'(state_dbg), 128'h0);

    // Vector table
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].do_load) do_load(vecs[i].mode, vecs[i].iv, vecs[i].exp_err);
      push(vecs[i].pt);
      wait_core_ready(n);
      check_int("issue_latency", n, 1);
      check("core_data_in", core_data_in, vecs[i].exp_core);
      wait_out_valid(n);
      check_int("out_latency", n, 4);
      check("out_data", out_data, vecs[i].exp_out);
      check_bit("err_quiet", err, 1'b0);
      take_output();
    end

    // Backpressure: three blocks fill the pipe, a fourth is refused
    do_load(2'b00, 128'h0, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      check_bit("bp_in_ready", in_ready, 1'b1);
      in_valid = 1'b1;
      in_data  = 128'(16 + i);
      exp_q.push_back(128'(17 + i));
      tick();
    end
    in_valid = 1'b0;
    check_bit("bp_full", in_ready, 1'b0);
    in_valid = 1'b1;
    in_data  = 128'hDEAD;
    seen_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready) seen_bad = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check_bit("bp_refused", seen_bad, 1'b0);
    check_bit("bp_out_valid_held", out_valid, 1'b1);
    check("bp_out_data_held", out_data, 128'h11);
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      if (out_valid) check("bp_drain", out_data, exp_q.pop_front());
      tick();
      n++;
    end
    out_ready = 1'b0;
    check_int("bp_drain_done", exp_q.size(), 0);
    for (int i = 0; i < 12; i++) tick();
    check_bit("bp_no_fourth", out_valid, 1'b0);
    check_bit("bp_idle", busy, 1'b0);

    // Core timeout in CBC leaves the chain alone
    do_load(2'b01, 128'h10, 1'b0);
    core_en = 1'b0;
    push(128'h01);
    wait_core_ready(n);
    check("to_core_in", core_data_in, 128'h11);
    push(128'h02);
    n = 1;
    seen_bad = 1'b0;
    while (!err && n < 300) begin
      if (out_valid) seen_bad = 1'b1;
      tick();
      n++;
    end
    check_int("to_err_delay", n, 65);
    check_bit("to_no_output", seen_bad, 1'b0);
    check("to_state_idle", 128'(state_dbg), 128'h0);
    core_en = 1'b1;
    tick();
    check_bit("to_err_width", err, 1'b0);
    check_bit("to_next_issue", core_ready, 1'b1);
    check("to_next_core_in", core_data_in, 128'h12);
    wait_out_valid(n);
    check_int("to_next_out_latency", n, 4);
    check("to_next_out", out_data, 128'h13);
    take_output();

    // Config load while busy is rejected
    do_load(2'b01, 128'h20, 1'b0);
    push(128'h01);
    wait_core_ready(n);
    check("cb_core_in", core_data_in, 128'h21);
    cfg_mode = 2'b00;
    cfg_iv   = 128'h55;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    check_bit("cb_err", err, 1'b1);
    tick();
    check_bit("cb_err_width", err, 1'b0);
    wait_out_valid(n);
    check_int("cb_out_latency", n, 2);
    check("cb_out", out_data, 128'h22);
    take_output();
    push(128'h00);
    wait_core_ready(n);
    check("cb_old_chain", core_data_in, 128'h22);
    wait_out_valid(n);
    check("cb_out2", out_data, 128'h23);
    take_output();

    // Reset mid-WAIT
    core_en = 1'b0;
    push(128'h07);
    wait_core_ready(n);
    tick();
    check("mw_in_wait", 128'(state_dbg), 128'h2);
    rst_n = 1'b0;
    #1;
    check_bit("mw_in_ready", in_ready, 1'b0);
    check_bit("mw_out_valid", out_valid, 1'b0);
    check("mw_out_data", out_data, 128'h0);
    check_bit("mw_core_ready", core_ready, 1'b0);
    check("mw_core_data_in", core_data_in, 128'h0);
    check_bit("mw_busy", busy, 1'b0);
    check_bit("mw_err", err, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_bit("mw_rel_ready", in_ready, 1'b1);
    cv_manual   = 1'b1;
    manual_data = 128'h99;
    tick();
    cv_manual = 1'b0;
    check_bit("mw_stray_ignored", out_valid, 1'b0);
    tick();
    check_bit("mw_stray_busy", busy, 1'b0);
    check_bit("mw_stray_err", err, 1'b0);
    core_en = 1'b1;
    push(128'h40);
    wait_core_ready(n);
    check("mw_ecb_after_reset", core_data_in, 128'h40);
    wait_out_valid(n);
    check("mw_out_after_reset", out_data, 128'h41);
    take_output();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
